// File: rtl/risc_v_mike_uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
//   uart_rx_state_e : receiver bit-timing states
//   boot_state_e    : loader frame-parsing states
//   BOOT_HDR_BYTE   : default frame header byte
package risc_v_mike_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_e;

  typedef enum logic [2:0] {
    B_WAIT_HDR,
    B_CNT_LO,
    B_CNT_HI,
    B_DATA,
    B_DONE
  } boot_state_e;

  localparam logic [7:0] BOOT_HDR_BYTE = 8'hA5;

endpackage

// File: rtl/risc_v_mike_uart_boot_loader_if.sv
// Instruction-memory write port.
//   we    : one-cycle write strobe
//   waddr : word address
//   wdata : 32-bit instruction word
// master drives the port (boot loader), slave receives it (memory).
interface risc_v_mike_uart_boot_loader_if #(
  parameter int AW = 8
) ();
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  modport master (output we, output waddr, output wdata);
  modport slave  (input  we, input  waddr, input  wdata);
endinterface

// File: rtl/risc_v_mike_uart_boot_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, byte assembly.
//   clk, rst    : system clock, async active-low reset
//   rx          : serial input, idle high, asynchronous to clk
//   byte_data   : last received byte (valid while byte_valid is high)
//   byte_valid  : one-cycle pulse after a good stop bit
//   frame_err   : one-cycle pulse after a low stop bit (byte dropped)
module risc_v_mike_uart_rx
  import risc_v_mike_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  uart_rx_state_e state_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          valid_q, ferr_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RX_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      // NOTE: pulse outputs default low each cycle and are raised only by the
      // branch that detects the event; this keeps them exactly one cycle wide.
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (rx_prev_q && !rx_sync_q) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state_q   <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_sync_q, shift_q[7:1]};  // LSB arrives first
            if (bit_idx_q == 3'd7) state_q <= RX_STOP;
            else bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (rx_sync_q) valid_q <= 1'b1;
            else           ferr_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/risc_v_mike_uart_boot_loader.sv
// UART boot loader: receives  HDR, N_lo, N_hi, then N little-endian 32-bit
// words, and writes them to instruction memory starting at LOAD_BASE. The core
// is held in reset until the last word is written.
//   clk, rst   : system clock, async active-low reset
//   rx         : UART serial input
//   imem       : instruction-memory write port (we / waddr / wdata)
//   cpu_rst_n  : core reset, released together with the last write
//   load_busy  : header accepted, image not yet complete
//   load_done  : sticky, image complete
//   frame_err  : one-cycle pulse on a bad stop bit
module risc_v_mike_uart_boot_loader
  import risc_v_mike_pkg::*;
#(
  parameter int         CLK_FREQ_HZ     = 100_000_000,
  parameter int         BAUD_RATE       = 115_200,
  parameter int         IMEM_ADDR_WIDTH = 8,
  parameter int         LOAD_BASE       = 0,
  parameter logic [7:0] HDR_BYTE        = BOOT_HDR_BYTE
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  risc_v_mike_uart_boot_loader_if.master imem,
  output logic cpu_rst_n,
  output logic load_busy,
  output logic load_done,
  output logic frame_err
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [IMEM_ADDR_WIDTH-1:0] BASE = IMEM_ADDR_WIDTH'(LOAD_BASE);

  logic [7:0] byte_data;
  logic       byte_valid;

  risc_v_mike_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  boot_state_e                state_q;
  logic [7:0]                 cnt_lo_q;
  logic [15:0]                words_q;
  logic [31:0]                word_q;
  logic [1:0]                 byte_idx_q;
  logic [IMEM_ADDR_WIDTH-1:0] waddr_q;
  logic                       we_q, busy_q, done_q, cpu_rst_n_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= B_WAIT_HDR;
      cnt_lo_q    <= '0;
      words_q     <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      waddr_q     <= BASE;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // Address advances the cycle after the strobe, so it is stable during it.
      if (we_q) waddr_q <= waddr_q + 1'b1;

      if (frame_err) begin
        // A broken byte aborts the frame; any partial word is discarded.
        if (state_q != B_DONE) begin
          state_q    <= B_WAIT_HDR;
          busy_q     <= 1'b0;
          byte_idx_q <= '0;
        end
      end else if (byte_valid) begin
        case (state_q)
          B_WAIT_HDR: begin
            if (byte_data == HDR_BYTE) begin
              state_q    <= B_CNT_LO;
              busy_q     <= 1'b1;
              waddr_q    <= BASE;
              byte_idx_q <= '0;
            end
          end
          B_CNT_LO: begin
            cnt_lo_q <= byte_data;
            state_q  <= B_CNT_HI;
          end
          B_CNT_HI: begin
            if ({byte_data, cnt_lo_q} == 16'd0) begin
              state_q     <= B_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else begin
              words_q <= {byte_data, cnt_lo_q};
              state_q <= B_DATA;
            end
          end
          B_DATA: begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
            byte_idx_q <= byte_idx_q + 1'b1;
            if (byte_idx_q == 2'd3) begin
              we_q    <= 1'b1;
              words_q <= words_q - 1'b1;
              if (words_q == 16'd1) begin
                state_q     <= B_DONE;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                cpu_rst_n_q <= 1'b1;
              end
            end
          end
          default: ;  // B_DONE: only reset leaves
        endcase
      end
    end
  end

  assign imem.we    = we_q;
  assign imem.waddr = waddr_q;
  assign imem.wdata = word_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;

endmodule

// File: tb/tb_risc_v_mike_uart_boot_loader.sv
module tb_risc_v_mike_uart_boot_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic cpu_rst_n0, load_busy0, load_done0, frame_err0;
  logic cpu_rst_n1, load_busy1, load_done1, frame_err1;

  risc_v_mike_uart_boot_loader_if #(.AW(4)) imem0 ();
  risc_v_mike_uart_boot_loader_if #(.AW(4)) imem1 ();

  risc_v_mike_uart_boot_loader #(
    .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .IMEM_ADDR_WIDTH(4), .LOAD_BASE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .imem(imem0.master),
    .cpu_rst_n(cpu_rst_n0), .load_busy(load_busy0), .load_done(load_done0), .frame_err(frame_err0)
  );

  risc_v_mike_uart_boot_loader #(
    .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .IMEM_ADDR_WIDTH(4), .LOAD_BASE(14)
  ) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .imem(imem1.master),
    .cpu_rst_n(cpu_rst_n1), .load_busy(load_busy1), .load_done(load_done1), .frame_err(frame_err1)
  );

  always #5 clk = ~clk;

  int   total_cnt = 0;
  int   pass_cnt  = 0;
  wr_t  exp0_q[$];
  wr_t  exp1_q[$];
  int   fe0_cnt = 0;
  logic fe0_prev = 1'b0, we0_prev = 1'b0, we1_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: parse a byte stream into the writes it must produce.
  // Only complete words are written; the last word of the frame releases the core.
  task automatic model(input byte_q_t b, input int base, input int which);
    int i = 0;
    int n;
    wr_t e;
    while (i < b.size() && b[i] != 8'hA5) i++;
    if (i + 2 >= b.size()) return;
    n = int'(b[i+1]) + 256 * int'(b[i+2]);
    i += 3;
    for (int w = 0; w < n && i + 3 < b.size(); w++) begin
      e.addr = 4'((base + w) % 16);
      e.data = {b[i+3], b[i+2], b[i+1], b[i]};
      e.last = (w == n - 1);
      if (which == 0) exp0_q.push_back(e);
      else exp1_q.push_back(e);
      i += 4;
    end
  endtask

  function automatic byte_q_t make_frame(input int n);
    byte_q_t q;
    q = {8'hA5, 8'(n), 8'(n >> 8)};
    for (int k = 0; k < 4 * n; k++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic set_line(input int line, input logic v);
    if (line == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int line);
    set_line(line, 1'b0);
    repeat (10) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      set_line(line, b[k]);
      repeat (10) @(posedge clk);
    end
    set_line(line, stop_bit);
    repeat (10) @(posedge clk);
    set_line(line, 1'b1);
    repeat (15) @(posedge clk);
  endtask

  task automatic send_bytes(input byte_q_t b, input int line);
    foreach (b[k]) send_byte(b[k], 1'b1, line);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check({name, "_drain0"}, 64'(exp0_q.size()), 64'd0);
    check({name, "_drain1"}, 64'(exp1_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_we",    imem0.we,   1'b0);
    check("rst_waddr", imem0.waddr, 4'd0);
    check("rst_waddr_base14", imem1.waddr, 4'd14);
    check("rst_cpu_rst_n", cpu_rst_n0, 1'b0);
    check("rst_busy",  load_busy0, 1'b0);
    check("rst_done",  load_done0, 1'b0);
    check("rst_ferr",  frame_err0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // Write/pulse monitor: pops expected writes whenever a strobe appears.
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      if (imem0.we) begin
        check("we0_width", we0_prev, 1'b0);
        if (exp0_q.size() == 0) check("unexpected_write0", imem0.we, 1'b0);
        else begin
          e = exp0_q.pop_front();
          check("waddr0", imem0.waddr, e.addr);
          check("wdata0", imem0.wdata, e.data);
          check("done_at_we0", load_done0, e.last);
          check("cpu_rst_n_at_we0", cpu_rst_n0, e.last);
          check("busy_at_we0", load_busy0, !e.last);
        end
      end
      if (imem1.we) begin
        check("we1_width", we1_prev, 1'b0);
        if (exp1_q.size() == 0) check("unexpected_write1", imem1.we, 1'b0);
        else begin
          e = exp1_q.pop_front();
          check("waddr1", imem1.waddr, e.addr);
          check("wdata1", imem1.wdata, e.data);
          check("done_at_we1", load_done1, e.last);
          check("cpu_rst_n_at_we1", cpu_rst_n1, e.last);
        end
      end
      if (frame_err0 && fe0_prev) check("ferr_width", fe0_prev, 1'b0);
      if (frame_err0 && !fe0_prev) fe0_cnt++;
    end
    fe0_prev <= frame_err0;
    we0_prev <= imem0.we;
    we1_prev <= imem1.we;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t f;
    int fe_before;

    do_reset();

    // 1: single-word image
    f = {8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    model(f, 0, 0);
    send_bytes(f, 0);
    drain("t1");
    check("t1_done", load_done0, 1'b1);
    check("t1_cpu_rst_n", cpu_rst_n0, 1'b1);

    // 2: leading junk, then two random words
    do_reset();
    f = {8'h00, 8'hFF, 8'h3C};
    f = {f, make_frame(2)};
    model(f, 0, 0);
    send_bytes(f, 0);
    drain("t2");
    check("t2_done", load_done0, 1'b1);

    // 3: bad stop bit mid-frame after one good word
    do_reset();
    f = make_frame(2);
    f = f[0:7];
    model(f, 0, 0);
    send_bytes(f, 0);
    send_byte(8'($urandom), 1'b1, 0);
    fe_before = fe0_cnt;
    send_byte(8'($urandom), 1'b0, 0);
    drain("t3a");
    check("t3_ferr_pulse", 64'(fe0_cnt), 64'(fe_before + 1));
    check("t3_waddr_kept", imem0.waddr, 4'd1);
    check("t3_not_done", load_done0, 1'b0);
    f = make_frame(2);
    model(f, 0, 0);
    send_bytes(f, 0);
    drain("t3b");
    check("t3_done", load_done0, 1'b1);

    // 4: short glitch on rx, then a normal frame
    do_reset();
    fe_before = fe0_cnt;
    @(negedge clk) rx0 = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    repeat (60) @(posedge clk);
    check("t4_no_ferr", 64'(fe0_cnt), 64'(fe_before));
    check("t4_busy", load_busy0, 1'b0);
    f = make_frame(1);
    model(f, 0, 0);
    send_bytes(f, 0);
    drain("t4");
    check("t4_done", load_done0, 1'b1);

    // 5: empty image, then traffic that must be ignored
    do_reset();
    send_bytes({8'hA5, 8'h00, 8'h00}, 0);
    check("t5_done", load_done0, 1'b1);
    check("t5_cpu_rst_n", cpu_rst_n0, 1'b1);
    check("t5_busy", load_busy0, 1'b0);
    send_bytes(make_frame(1), 0);
    fe_before = fe0_cnt;
    send_byte(8'h55, 1'b0, 0);
    check("t5_ferr_in_done", 64'(fe0_cnt), 64'(fe_before + 1));
    check("t5_still_done", load_done0, 1'b1);
    check("t5_waddr", imem0.waddr, 4'd0);

    // 6: reset after 2 of 3 words, then a full reload
    do_reset();
    f = make_frame(3);
    f = f[0:10];
    model(f, 0, 0);
    send_bytes(f, 0);
    drain("t6a");
    check("t6_busy_before", load_busy0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_waddr", imem0.waddr, 4'd0);
    check("t6_busy", load_busy0, 1'b0);
    check("t6_done", load_done0, 1'b0);
    check("t6_cpu_rst_n", cpu_rst_n0, 1'b0);
    check("t6_we", imem0.we, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    f = make_frame(3);
    model(f, 0, 0);
    send_bytes(f, 0);
    drain("t6b");
    check("t6_done_after", load_done0, 1'b1);

    // 7: base 14, three words wrap to address 0
    f = make_frame(3);
    model(f, 14, 1);
    send_bytes(f, 1);
    drain("t7");
    check("t7_done", load_done1, 1'b1);
    check("t7_waddr_wrapped", imem1.waddr, 4'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
